// File: rtl/merge_rr.sv
// merge_rr: round-robin arbiter sharing one native-bus slave among N_MASTERS masters
module merge_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS*(ADDR_W+37)-1:0] m_req,
  output logic [N_MASTERS*33-1:0]          m_resp,
  output logic [ADDR_W+36:0]               s_req,
  input  logic [32:0]                      s_resp,
  output logic [N_MASTERS-1:0]             grant,
  output logic                             busy
);
  localparam int RW = ADDR_W + 37;
  localparam int GW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        state_q, state_d;
  logic [GW-1:0] gi_q, gi_d, lp_q, lp_d, sel;
  logic [N_MASTERS-1:0] vld;
  logic [RW-1:0] req_a [N_MASTERS];
  for (genvar g = 0; g < N_MASTERS; g++) begin : g_slice
    assign req_a[g] = m_req[g*RW +: RW];
    assign vld[g] = req_a[g][RW-1];
    assign m_resp[g*33 +: 33] = {s_resp[32:1], s_resp[0] & grant[g]};
  end
  // first valid master after the last-served one; lower distance overwrites later
  always_comb begin
    sel = '0;
    for (int k = N_MASTERS; k >= 1; k--)
      if (vld[(int'(lp_q) + k) % N_MASTERS]) sel = GW'((int'(lp_q) + k) % N_MASTERS);
  end
  // state, grant index and last-served pointer; reset gives master 0 first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gi_q    <= '0;
      lp_q    <= GW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gi_q    <= gi_d;
      lp_q    <= lp_d;
    end
  end
  // grant on any valid; release on slave ready or when the granted master abandons
  always_comb begin
    state_d = state_q;
    gi_d    = gi_q;
    lp_d    = lp_q;
    if (state_q == IDLE) begin
      if (|vld) begin
        state_d = BUSY;
        gi_d    = sel;
      end
    end else if (s_resp[0] || !vld[gi_q]) begin
      state_d = IDLE;
      lp_d    = gi_q;
    end
  end
  // slave sees only the granted master; everything is quiet while idle
  always_comb begin
    busy  = state_q == BUSY;
    s_req = busy ? req_a[gi_q] : '0;
    grant = busy ? N_MASTERS'(1) << gi_q : '0;
  end
endmodule

// File: tb/tb_merge_rr.sv
// tb_merge_rr: table-driven, directed and randomized checks of merge_rr against a reference model
module tb_merge_rr;
  localparam int N  = 3;
  localparam int RW = 69;
  logic clk = 0, rst = 1, ready = 0;
  logic [31:0] rdata = 0;
  logic [2:0]  vmask = 0;
  logic [31:0] addr [N], wdata [N];
  logic [3:0]  wstrb [N];
  logic [N*RW-1:0] m_req;
  logic [N*33-1:0] m_resp;
  logic [RW-1:0]   s_req;
  logic [N-1:0]    grant;
  logic            busy;
  int checks = 0, errors = 0;
  bit mb;
  int mg, ml;

  merge_rr #(.N_MASTERS(N), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp), .s_req(s_req),
    .s_resp({rdata, ready}), .grant(grant), .busy(busy));

  always #5 clk = ~clk;

  always_comb begin
    m_req = '0;
    for (int i = 0; i < N; i++) m_req[i*RW +: RW] = {vmask[i], addr[i], wdata[i], wstrb[i]};
  end

  typedef struct {bit r; bit [2:0] v; bit rdy; bit [2:0] g; bit b; bit [2:0] rr;} vec_t;
  vec_t tbl [24];

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  task automatic model_check();
    logic [RW-1:0] es;
    logic [N*33-1:0] er;
    es = mb ? {vmask[mg], addr[mg], wdata[mg], wstrb[mg]} : '0;
    for (int i = 0; i < N; i++) er[i*33 +: 33] = {rdata, ready && mb && mg == i};
    chk("model_s_req", 128'(s_req), 128'(es));
    chk("model_grant", 128'(grant), mb ? 128'(1) << mg : 128'(0));
    chk("model_busy", 128'(busy), 128'(mb));
    chk("model_m_resp", 128'(m_resp), 128'(er));
  endtask

  task automatic model_step();
    if (rst) begin
      mb = 0; mg = 0; ml = N - 1;
    end else if (!mb) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (ml + k) % N;
        if (vmask[idx]) begin
          mb = 1; mg = idx;
          break;
        end
      end
    end else if (ready || !vmask[mg]) begin
      mb = 0; ml = mg;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    addr[0] = 32'hA000_0000; wdata[0] = 32'h0000_0A0A; wstrb[0] = 4'h1;
    addr[1] = 32'h0000_1040; wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'hF;
    addr[2] = 32'hC000_0C0C; wdata[2] = 32'h2222_3333; wstrb[2] = 4'h6;
    mb = 0; mg = 0; ml = N - 1;
    tbl[0]  = '{1, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[1]  = '{1, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[2]  = '{0, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[3]  = '{0, 3'b111, 1, 3'b001, 1, 3'b001};
    tbl[4]  = '{0, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[5]  = '{0, 3'b111, 1, 3'b010, 1, 3'b010};
    tbl[6]  = '{0, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[7]  = '{0, 3'b111, 1, 3'b100, 1, 3'b100};
    tbl[8]  = '{0, 3'b111, 0, 3'b000, 0, 3'b000};
    tbl[9]  = '{0, 3'b111, 1, 3'b001, 1, 3'b001};
    tbl[10] = '{0, 3'b101, 0, 3'b000, 0, 3'b000};
    tbl[11] = '{0, 3'b101, 0, 3'b100, 1, 3'b000};
    tbl[12] = '{0, 3'b001, 0, 3'b100, 1, 3'b000};
    tbl[13] = '{0, 3'b001, 0, 3'b000, 0, 3'b000};
    tbl[14] = '{0, 3'b001, 0, 3'b001, 1, 3'b000};
    tbl[15] = '{0, 3'b001, 1, 3'b001, 1, 3'b001};
    tbl[16] = '{0, 3'b000, 1, 3'b000, 0, 3'b000};
    tbl[17] = '{0, 3'b000, 1, 3'b000, 0, 3'b000};
    tbl[18] = '{0, 3'b010, 0, 3'b000, 0, 3'b000};
    tbl[19] = '{1, 3'b010, 0, 3'b010, 1, 3'b000};
    tbl[20] = '{0, 3'b011, 1, 3'b000, 0, 3'b000};
    tbl[21] = '{0, 3'b011, 0, 3'b001, 1, 3'b000};
    tbl[22] = '{0, 3'b011, 1, 3'b001, 1, 3'b001};
    tbl[23] = '{0, 3'b000, 0, 3'b000, 0, 3'b000};
    rst = 1; vmask = 3'b111;
    at_pos();
    for (int t = 0; t < 24; t++) begin
      rst = tbl[t].r; vmask = tbl[t].v; ready = tbl[t].rdy; rdata = 32'h1234_5678;
      at_neg();
      chk($sformatf("tbl%0d_grant", t), 128'(grant), 128'(tbl[t].g));
      chk($sformatf("tbl%0d_busy", t), 128'(busy), 128'(tbl[t].b));
      chk($sformatf("tbl%0d_ready", t), 128'({m_resp[66], m_resp[33], m_resp[0]}), 128'(tbl[t].rr));
      at_pos();
    end
    rst = 0; vmask = 3'b010; ready = 0;
    at_neg();
    at_pos();
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("single_s_req", 128'(s_req), 128'({1'b1, 32'h0000_1040, 32'hDEAD_BEEF, 4'hF}));
      chk("single_no_ready", 128'(m_resp[66] | m_resp[33] | m_resp[0]), 128'(0));
      at_pos();
    end
    ready = 1; rdata = 32'h1234_5678;
    at_neg();
    chk("single_m_resp", 128'(m_resp),
        128'({32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0}));
    at_pos();
    vmask = 0; ready = 0;
    at_neg();
    chk("single_busy_fall", 128'(busy), 128'(0));
    at_pos();
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 49) == 0;
      vmask = 3'($urandom);
      ready = $urandom_range(0, 3) == 0;
      rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        addr[i] = $urandom; wdata[i] = $urandom; wstrb[i] = 4'($urandom);
      end
      at_neg();
      at_pos();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
